// File: rtl/rca_sub_seq_ctrl.sv
// Sequential WIDTH-bit subtractor: one 4-bit ripple slice, one nibble per cycle, valid/ready on both sides.
// Optional macro RCA_SEQ_ADDSUB_EN adds an op_add port selecting a+b instead of a-b.
module rca_sub_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef RCA_SEQ_ADDSUB_EN
    input  logic             op_add,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic              carry_reg, carry_next;
    logic              sub_reg, sub_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  diff_reg, diff_next;
    logic              borrow_reg, borrow_next;
    logic              ovf_reg, ovf_next;

    logic              op_sub;
`ifdef RCA_SEQ_ADDSUB_EN
    assign op_sub = ~op_add;
`else
    assign op_sub = 1'b1;
`endif

    // b_reg holds the slice's second operand: ~b when subtracting, b when adding.
    logic [3:0] a_nib, b_nib, s_nib;
    logic [4:0] c_chain;

    assign a_nib      = a_reg[{idx_reg, 2'b00} +: 4];
    assign b_nib      = b_reg[{idx_reg, 2'b00} +: 4];
    assign c_chain[0] = carry_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign s_nib[gi]      = a_nib[gi] ^ b_nib[gi] ^ c_chain[gi];
            assign c_chain[gi+1]  = (a_nib[gi] & b_nib[gi]) | (c_chain[gi] & (a_nib[gi] ^ b_nib[gi]));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        carry_next  = carry_reg;
        sub_next    = sub_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        ovf_next    = ovf_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = op_sub ? ~b : b;
                    sub_next   = op_sub;
                    carry_next = op_sub;
                    idx_next   = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                diff_next[{idx_reg, 2'b00} +: 4] = s_nib;
                carry_next = c_chain[4];
                if (idx_reg == IDXW'(NSLICE - 1)) begin
                    state_next  = S_DONE;
                    idx_next    = '0;
                    borrow_next = c_chain[4] ^ sub_reg;
                    // With b already inverted for subtraction, one formula covers both modes.
                    ovf_next    = ~(a_reg[MSB] ^ b_reg[MSB]) & (a_reg[MSB] ^ s_nib[3]);
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            carry_reg  <= 1'b1;
            sub_reg    <= 1'b1;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            carry_reg  <= carry_next;
            sub_reg    <= sub_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;
    assign ovf       = ovf_reg;
endmodule

// File: tb/tb_rca_sub_seq_ctrl.sv
// Self-checking bench for rca_sub_seq_ctrl (WIDTH=32) against an arithmetic reference model.
// Exercises the op_add path only when RCA_SEQ_ADDSUB_EN is defined.
module tb_rca_sub_seq_ctrl;
    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a, b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  diff;
    logic              borrow, ovf;
`ifdef RCA_SEQ_ADDSUB_EN
    logic              op_add;
`endif

    int checks = 0;
    int passes = 0;

    rca_sub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef RCA_SEQ_ADDSUB_EN
        .op_add    (op_add),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Plain arithmetic reference: carry/borrow from unsigned compare, overflow from signed range.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input bit add,
                                  output logic [31:0] d, output logic br, output logic ov);
        longint sx, sy, r;
        logic [32:0] w;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (add) begin
            w  = {1'b0, x} + {1'b0, y};
            d  = w[31:0];
            br = w[32];
            r  = sx + sy;
        end else begin
            d  = x - y;
            br = (x < y);
            r  = sx - sy;
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        logic [33:0] got;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
`ifdef RCA_SEQ_ADDSUB_EN
        op_add = 1'b0;
`endif
        tick; tick;
        rst = 1'b0;
        got = {diff, borrow, ovf};
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_hs: in_ready/out_valid=%b, required 10", {in_ready, out_valid});
        else passes++;
        checks++;
        if (got !== 34'd0) $display("FAIL reset_out: diff/borrow/ovf=%h, required 0", got);
        else passes++;
    endtask

    task automatic test_directed;
        logic [31:0] va [3] = '{32'd5, 32'd3, 32'h8000_0000};
        logic [31:0] vb [3] = '{32'd3, 32'd5, 32'd1};
        logic [31:0] ed; logic eb, eo; int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model(va[i], vb[i], 1'b0, ed, eb, eo);
            start_op(va[i], vb[i]);
            wait_valid(n);
            checks++;
            if (n !== NSLICE) $display("FAIL directed_latency: %0d edges, required %0d", n, NSLICE);
            else passes++;
            checks++;
            if ({diff, borrow, ovf} !== {ed, eb, eo})
                $display("FAIL directed_result: a=%h b=%h got diff=%h b=%b o=%b, required diff=%h b=%b o=%b",
                         va[i], vb[i], diff, borrow, ovf, ed, eb, eo);
            else passes++;
            $display("op sub a=%h b=%h diff=%h borrow=%b ovf=%b", va[i], vb[i], diff, borrow, ovf);
            tick;
            checks++;
            if ({in_ready, out_valid} !== 2'b10)
                $display("FAIL directed_release: in_ready/out_valid=%b, required 10", {in_ready, out_valid});
            else passes++;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] x, y, ed; logic eb, eo; int n;
        x = $urandom; y = $urandom;
        model(x, y, 1'b0, ed, eb, eo);
        out_ready = 1'b0;
        start_op(x, y);
        wait_valid(n);
        checks++;
        if (n !== NSLICE) $display("FAIL bp_latency: %0d edges, required %0d", n, NSLICE);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_valid, in_ready, diff, borrow, ovf} !== {1'b1, 1'b0, ed, eb, eo})
                $display("FAIL bp_hold: cycle %0d ov/ir=%b%b diff=%h b=%b o=%b, required 10 diff=%h b=%b o=%b",
                         i, out_valid, in_ready, diff, borrow, ovf, ed, eb, eo);
            else passes++;
            tick;
        end
        $display("op sub a=%h b=%h diff=%h borrow=%b ovf=%b (held)", x, y, diff, borrow, ovf);
        out_ready = 1'b1;
        tick;
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_release: in_ready/out_valid=%b, required 10", {in_ready, out_valid});
        else passes++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] x1, y1, x2, y2, ed; logic eb, eo; int n;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        out_ready = 1'b0;
        in_valid = 1'b1; a = x1; b = y1;
        tick;
        a = x2; b = y2;
        tick;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_busy: in_ready=%b, required 0", in_ready);
        else passes++;
        wait_valid(n);
        model(x1, y1, 1'b0, ed, eb, eo);
        checks++;
        if ({diff, borrow, ovf} !== {ed, eb, eo})
            $display("FAIL b2b_first: diff=%h b=%b o=%b, required diff=%h b=%b o=%b", diff, borrow, ovf, ed, eb, eo);
        else passes++;
        $display("op sub a=%h b=%h diff=%h borrow=%b ovf=%b", x1, y1, diff, borrow, ovf);
        out_ready = 1'b1;
        tick;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_idle: in_ready=%b, required 1", in_ready);
        else passes++;
        tick;
        in_valid = 1'b0;
        wait_valid(n);
        checks++;
        if (n !== NSLICE) $display("FAIL b2b_latency: %0d edges, required %0d", n, NSLICE);
        else passes++;
        model(x2, y2, 1'b0, ed, eb, eo);
        checks++;
        if ({diff, borrow, ovf} !== {ed, eb, eo})
            $display("FAIL b2b_second: diff=%h b=%b o=%b, required diff=%h b=%b o=%b", diff, borrow, ovf, ed, eb, eo);
        else passes++;
        $display("op sub a=%h b=%h diff=%h borrow=%b ovf=%b", x2, y2, diff, borrow, ovf);
        tick;
    endtask

    task automatic test_reset_midrun;
        logic [31:0] ed; logic eb, eo; int n;
        out_ready = 1'b1;
        start_op($urandom, $urandom);
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, diff} !== {1'b0, 1'b1, 32'd0})
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b diff=%h, required 0 1 0", out_valid, in_ready, diff);
        else passes++;
        model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ed, eb, eo);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(n);
        checks++;
        if ({diff, borrow, ovf} !== {ed, eb, eo})
            $display("FAIL midrun_fresh: diff=%h b=%b o=%b, required diff=%h b=%b o=%b", diff, borrow, ovf, ed, eb, eo);
        else passes++;
        $display("op sub a=ffffffff b=ffffffff diff=%h borrow=%b ovf=%b", diff, borrow, ovf);
        tick;
    endtask

    task automatic test_random;
        logic [31:0] x, y, ed; logic eb, eo, add; int n, k;
        for (int i = 0; i < 24; i++) begin
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 5))
                0: y = x;
                1: x = 32'h8000_0000;
                2: y = 32'h7FFF_FFFF;
                default: ;
            endcase
            add = 1'b0;
`ifdef RCA_SEQ_ADDSUB_EN
            add = $urandom_range(0, 1);
            op_add = add;
`endif
            model(x, y, add, ed, eb, eo);
            out_ready = 1'b0;
            start_op(x, y);
            wait_valid(n);
            checks++;
            if (n !== NSLICE || {diff, borrow, ovf} !== {ed, eb, eo})
                $display("FAIL random_op: add=%b a=%h b=%h lat=%0d diff=%h b=%b o=%b, required lat=%0d diff=%h b=%b o=%b",
                         add, x, y, n, diff, borrow, ovf, NSLICE, ed, eb, eo);
            else passes++;
            $display("op %s a=%h b=%h diff=%h borrow=%b ovf=%b", add ? "add" : "sub", x, y, diff, borrow, ovf);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) tick;
            out_ready = 1'b1;
            tick;
        end
`ifdef RCA_SEQ_ADDSUB_EN
        op_add = 1'b0;
`endif
    endtask

`ifdef RCA_SEQ_ADDSUB_EN
    task automatic test_addsub;
        logic [31:0] va [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] ed; logic eb, eo; int n;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model(va[i], 32'd1, 1'b1, ed, eb, eo);
            op_add = 1'b1;
            start_op(va[i], 32'd1);
            op_add = 1'b0;
            wait_valid(n);
            checks++;
            if ({diff, borrow, ovf} !== {ed, eb, eo})
                $display("FAIL addsub: a=%h diff=%h c=%b o=%b, required diff=%h c=%b o=%b", va[i], diff, borrow, ovf, ed, eb, eo);
            else passes++;
            $display("op add a=%h b=00000001 diff=%h carry=%b ovf=%b", va[i], diff, borrow, ovf);
            tick;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_back_to_back;
        test_reset_midrun;
        test_random;
`ifdef RCA_SEQ_ADDSUB_EN
        test_addsub;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
